// File: rtl/dmem_responder_if.sv
// Data-memory bus plus console TX byte stream between the CPU core (master)
// and the data-memory responder (slave).
interface dmem_responder_if #(
   parameter int DATA_W   = 8,
   parameter int D_ADDR_W = 12
);
   logic [D_ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0]   write_data;
   logic                data_memory_write_enable;
   logic                data_memory_output_enable;
   logic [DATA_W-1:0]   read_data;
   logic [DATA_W-1:0]   tx_data;
   logic                tx_valid;
   logic                tx_ready;

   // Core side: issues accesses and acts as the console byte sink.
   modport master (
      output data_addr, write_data, data_memory_write_enable,
             data_memory_output_enable, tx_ready,
      input  read_data, tx_data, tx_valid
   );

   // Responder side.
   modport slave (
      input  data_addr, write_data, data_memory_write_enable,
             data_memory_output_enable, tx_ready,
      output read_data, tx_data, tx_valid
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: target side of the core's data memory interface.
// Addresses below MMIO_BASE hit internal RAM; from MMIO_BASE upward sits a
// small register window: console TX FIFO, status, 16-bit cycle counter.
// Reads are combinational; writes commit at the rising edge of clk.
// Optional build macro DMEM_RESP_BUS_ERR_EN adds the bus_error output and
// the sticky buserr status bit for accesses to unmapped MMIO offsets.
module dmem_responder #(
   parameter int DATA_W     = 8,
   parameter int D_ADDR_W   = 12,
   parameter int MMIO_BASE  = 'hF00,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
`ifdef DMEM_RESP_BUS_ERR_EN
   ,
   output logic             bus_error
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CYC_W = 16;

   localparam logic [D_ADDR_W-1:0] BASE         = D_ADDR_W'(MMIO_BASE);
   localparam logic [D_ADDR_W-1:0] OFF_CON_DATA = D_ADDR_W'(0);
   localparam logic [D_ADDR_W-1:0] OFF_CON_STAT = D_ADDR_W'(1);
   localparam logic [D_ADDR_W-1:0] OFF_CYC_LO   = D_ADDR_W'(2);
   localparam logic [D_ADDR_W-1:0] OFF_CYC_HI   = D_ADDR_W'(3);
   localparam logic [CNT_W-1:0]    FULL_CNT     = CNT_W'(FIFO_DEPTH);

   // ---------------------------------------------------------------- decode
   logic                is_mmio;
   logic [D_ADDR_W-1:0] mmio_off;
   logic                wr;
   logic                rd;
   logic                sel_con_data;
   logic                sel_con_stat;
   logic                sel_cyc_lo;
   logic                sel_cyc_hi;

   assign is_mmio      = (bus.data_addr >= BASE);
   assign mmio_off     = bus.data_addr - BASE;
   assign wr           = bus.data_memory_write_enable;
   assign rd           = bus.data_memory_output_enable;
   assign sel_con_data = is_mmio && (mmio_off == OFF_CON_DATA);
   assign sel_con_stat = is_mmio && (mmio_off == OFF_CON_STAT);
   assign sel_cyc_lo   = is_mmio && (mmio_off == OFF_CYC_LO);
   assign sel_cyc_hi   = is_mmio && (mmio_off == OFF_CYC_HI);

   // ------------------------------------------------------------------ RAM
   logic [DATA_W-1:0] ram [MMIO_BASE];

   // RAM write port; contents survive reset.
   // NOTE: storage arrays carry no reset -- clearing them would need a
   // per-entry reset mux and nothing relies on their power-up value.
   always_ff @(posedge clk) begin
      if (wr && !is_mmio) ram[bus.data_addr] <= bus.write_data;
   end

   // ------------------------------------------------------------ TX FIFO
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              pop;
   logic              push_req;
   logic              push;
   logic              overflow;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign pop      = !empty && bus.tx_ready;
   assign push_req = wr && sel_con_data;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push     = push_req && (!full || pop);

   assign bus.tx_valid = !empty;
   assign bus.tx_data  = empty ? '0 : fifo_mem[rd_ptr];

   // FIFO payload storage.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.write_data;
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (wr && sel_con_stat)              overflow <= 1'b0;
         else if (push_req && full && !pop)   overflow <= 1'b1;
      end
   end

   // -------------------------------------------------------- cycle counter
   logic [CYC_W-1:0] cyc_count;
   logic [7:0]       hi_shadow;

   // Free-running counter (clear has priority) and high-byte snapshot taken
   // whenever the low byte is read, so LO-then-HI reads are coherent.
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_count <= '0;
         hi_shadow <= '0;
      end else begin
         if (wr && sel_cyc_lo) cyc_count <= '0;
         else                  cyc_count <= cyc_count + CYC_W'(1);
         if (rd && sel_cyc_lo) hi_shadow <= cyc_count[15:8];
      end
   end

   // ------------------------------------------------------------ bus error
   logic buserr_bit;

`ifdef DMEM_RESP_BUS_ERR_EN
   logic sel_unmapped;
   logic buserr_sticky;

   assign sel_unmapped = is_mmio && (mmio_off > OFF_CYC_HI);
   assign buserr_bit   = buserr_sticky;

   // One-cycle pulse after any access to an unmapped offset, plus sticky
   // status bit cleared by a status write.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_error     <= 1'b0;
         buserr_sticky <= 1'b0;
      end else begin
         bus_error <= sel_unmapped && (rd || wr);
         if (sel_unmapped && (rd || wr)) buserr_sticky <= 1'b1;
         else if (wr && sel_con_stat)    buserr_sticky <= 1'b0;
      end
   end
`else
   assign buserr_bit = 1'b0;
`endif

   // ----------------------------------------------------------- read path
   logic [DATA_W-1:0] status;

   // Status register image.
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned and infers a latch.
   always_comb begin
      status    = '0;
      status[0] = full;
      status[1] = empty;
      status[2] = overflow;
      status[3] = buserr_bit;
   end

   // Combinational read mux; a same-cycle write is seen only after the edge.
   always_comb begin
      bus.read_data = '0;
      if (rd) begin
         if (!is_mmio) begin
            bus.read_data = ram[bus.data_addr];
         end else if (sel_con_stat) begin
            bus.read_data = status;
         end else if (sel_cyc_lo) begin
            bus.read_data = DATA_W'(cyc_count[7:0]);
         end else if (sel_cyc_hi) begin
            bus.read_data = DATA_W'(hi_shadow);
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios with literal
// expectations plus randomized traffic against a queue/array-based model.
module tb_dmem_responder;
   localparam int DATA_W     = 8;
   localparam int D_ADDR_W   = 12;
   localparam int MMIO_BASE  = 'hF00;
   localparam int FIFO_DEPTH = 4;
`ifdef DMEM_RESP_BUS_ERR_EN
   localparam bit BE_EN = 1'b1;
`else
   localparam bit BE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_responder_if #(.DATA_W(DATA_W), .D_ADDR_W(D_ADDR_W)) bus ();
`ifdef DMEM_RESP_BUS_ERR_EN
   logic bus_error;
`endif

   dmem_responder #(
      .DATA_W(DATA_W), .D_ADDR_W(D_ADDR_W),
      .MMIO_BASE(MMIO_BASE), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef DMEM_RESP_BUS_ERR_EN
      ,
      .bus_error(bus_error)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   // ------------------------------------------------------------- model
   logic [7:0]  fifo_q [$];
   logic [7:0]  ram_m [int];
   int unsigned cyc_m;
   logic [7:0]  hi_m;
   bit          ovf_m;
   bit          berr_m;
   bit          berr_pulse_m;
   bit          model_ok = 1'b0;

   function automatic void exp_read(output bit known, output logic [7:0] v);
      int a;
      int off;
      a     = int'(bus.data_addr);
      known = 1'b1;
      v     = 8'h00;
      if (!bus.data_memory_output_enable) return;
      if (a < MMIO_BASE) begin
         if (ram_m.exists(a)) v = ram_m[a];
         else known = 1'b0;
         return;
      end
      off = a - MMIO_BASE;
      case (off)
         1: v = {4'b0, berr_m, ovf_m, fifo_q.size() == 0, fifo_q.size() == FIFO_DEPTH};
         2: v = cyc_m[7:0];
         3: v = hi_m;
         default: v = 8'h00;
      endcase
   endfunction

   task automatic model_step();
      int  a;
      bit  we;
      bit  oe;
      bit  pop;
      bit  full;
      bit  unmapped;
      a  = int'(bus.data_addr);
      we = bus.data_memory_write_enable;
      oe = bus.data_memory_output_enable;
      if (reset) begin
         fifo_q.delete();
         ovf_m        = 1'b0;
         berr_m       = 1'b0;
         berr_pulse_m = 1'b0;
         cyc_m        = 0;
         hi_m         = 8'h00;
         model_ok     = 1'b1;
         return;
      end
      pop  = (fifo_q.size() != 0) && bus.tx_ready;
      full = (fifo_q.size() == FIFO_DEPTH);
      if (pop) void'(fifo_q.pop_front());
      if (we && a == MMIO_BASE) begin
         if (!full || pop) fifo_q.push_back(bus.write_data);
         else              ovf_m = 1'b1;
      end
      if (we && a == MMIO_BASE + 1) begin
         ovf_m  = 1'b0;
         berr_m = 1'b0;
      end
      unmapped     = BE_EN && (we || oe) && (a >= MMIO_BASE + 4);
      berr_pulse_m = unmapped;
      if (unmapped) berr_m = 1'b1;
      if (oe && a == MMIO_BASE + 2) hi_m = cyc_m[15:8];
      if (we && a == MMIO_BASE + 2) cyc_m = 0;
      else                          cyc_m = (cyc_m + 1) & 32'hFFFF;
      if (we && a < MMIO_BASE) ram_m[a] = bus.write_data;
   endtask

   // Compare DUT outputs with the model every cycle, then advance the model
   // by the edge that follows (inputs are stable from here to that edge).
   initial begin
      bit         known;
      logic [7:0] v;
      forever begin
         @(negedge clk);
         if (model_ok) begin
            check("m_tx_valid", bus.tx_valid, fifo_q.size() != 0);
            check("m_tx_data", bus.tx_data, (fifo_q.size() != 0) ? fifo_q[0] : 8'h00);
            exp_read(known, v);
            if (known) check("m_read_data", bus.read_data, v);
`ifdef DMEM_RESP_BUS_ERR_EN
            check("m_bus_error", bus_error, berr_pulse_m);
`endif
         end
         model_step();
      end
   end

   // ----------------------------------------------------------- driver
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [11:0] a, input logic [7:0] d, input bit we, input bit oe);
      bus.data_addr                 = a;
      bus.write_data                = d;
      bus.data_memory_write_enable  = we;
      bus.data_memory_output_enable = oe;
   endtask

   task automatic wr(input logic [11:0] a, input logic [7:0] d);
      drive(a, d, 1'b1, 1'b0);
      tick();
   endtask

   task automatic rd_chk(input string name, input logic [11:0] a, input logic [7:0] exp);
      drive(a, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      check(name, bus.read_data, exp);
      tick();
   endtask

   task automatic idle(input int n);
      drive(12'h000, 8'h00, 1'b0, 1'b0);
      repeat (n) tick();
   endtask

   initial begin
      reset        = 1'b1;
      bus.tx_ready = 1'b0;
      drive(12'h000, 8'h00, 1'b0, 1'b0);
      repeat (2) tick();
      reset = 1'b0;

      // Reset state.
      drive(12'hF02, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      check("rst_cyc_lo", bus.read_data, 8'h00);
      check("rst_tx_valid", bus.tx_valid, 1'b0);
      check("rst_tx_data", bus.tx_data, 8'h00);
      tick();
      rd_chk("rst_status", 12'hF01, 8'h02);

      // RAM access.
      wr(12'h010, 8'hA5);
      rd_chk("ram_rd", 12'h010, 8'hA5);
      drive(12'h011, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      check("ram_oe0", bus.read_data, 8'h00);
      tick();

      // FIFO fill and overflow.
      for (int i = 0; i < 4; i++) wr(12'hF00, 8'(8'h41 + i));
      rd_chk("fifo_full", 12'hF01, 8'h01);
      wr(12'hF00, 8'h45);
      rd_chk("fifo_ovf", 12'hF01, 8'h05);
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(12'h000, 8'h00, 1'b0, 1'b0);
         @(negedge clk);
         check("drain_data", bus.tx_data, 16'(8'h41 + i));
         check("drain_valid", bus.tx_valid, 1'b1);
         tick();
      end
      rd_chk("drained_status", 12'hF01, 8'h06);
      wr(12'hF01, 8'hFF);
      rd_chk("ovf_cleared", 12'hF01, 8'h02);

      // Simultaneous push and pop while full.
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) wr(12'hF00, 8'(8'h61 + i));
      bus.tx_ready = 1'b1;
      drive(12'hF00, 8'h55, 1'b1, 1'b0);
      @(negedge clk);
      check("pp_head", bus.tx_data, 8'h61);
      tick();
      bus.tx_ready = 1'b0;
      rd_chk("pp_status", 12'hF01, 8'h01);
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(12'h000, 8'h00, 1'b0, 1'b0);
         @(negedge clk);
         check("pp_drain", bus.tx_data, (i < 3) ? 16'(8'h62 + i) : 16'h0055);
         tick();
      end
      rd_chk("pp_end_status", 12'hF01, 8'h02);
      bus.tx_ready = 1'b0;

      // Cycle counter: clear, snapshot coherency, wrap.
      wr(12'hF02, 8'h00);
      idle(2);
      rd_chk("cyc_clr", 12'hF02, 8'h02);
      wr(12'hF02, 8'h00);
      idle(12'h1FE);
      rd_chk("cyc_lo_fe", 12'hF02, 8'hFE);
      rd_chk("cyc_hi_01", 12'hF03, 8'h01);
      idle(2);
      rd_chk("cyc_hi_hold", 12'hF03, 8'h01);
      wr(12'hF02, 8'h00);
      idle(16'hFFFE);
      rd_chk("cyc_lo_fffe", 12'hF02, 8'hFE);
      rd_chk("cyc_hi_ff", 12'hF03, 8'hFF);
      rd_chk("cyc_wrap_lo", 12'hF02, 8'h00);
      rd_chk("cyc_wrap_hi", 12'hF03, 8'h00);

      // Reset mid-drain.
      for (int i = 0; i < 3; i++) wr(12'hF00, 8'(8'h71 + i));
      bus.tx_ready = 1'b1;
      drive(12'h000, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      check("mid_head", bus.tx_data, 8'h71);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(12'hF02, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      check("mid_rst_valid", bus.tx_valid, 1'b0);
      check("mid_rst_cyc", bus.read_data, 8'h00);
      tick();
      rd_chk("mid_rst_status", 12'hF01, 8'h02);
      rd_chk("mid_rst_ram", 12'h010, 8'hA5);
      bus.tx_ready = 1'b0;

      // Unmapped MMIO access.
      drive(12'hF07, 8'h00, 1'b0, 1'b1);
      tick();
      drive(12'hF01, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
`ifdef DMEM_RESP_BUS_ERR_EN
      check("be_pulse", bus_error, 1'b1);
      check("be_status", bus.read_data, 8'h0A);
`else
      check("be_absent_status", bus.read_data, 8'h02);
`endif
      tick();
      drive(12'h000, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
`ifdef DMEM_RESP_BUS_ERR_EN
      check("be_pulse_end", bus_error, 1'b0);
`endif
      tick();
      wr(12'hF01, 8'h00);
      rd_chk("be_cleared", 12'hF01, 8'h02);

      // Randomized traffic checked by the model.
      for (int n = 0; n < 3000; n++) begin
         int unsigned r;
         logic [11:0] a;
         reset = ($urandom_range(0, 299) == 0);
         r = $urandom_range(0, 9);
         if (r < 5)      a = 12'($urandom_range(0, 31));
         else if (r < 7) a = 12'hF00;
         else            a = 12'(MMIO_BASE + $urandom_range(0, 7));
         drive(a, 8'($urandom), reset ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         bus.tx_ready = 1'($urandom_range(0, 1));
         tick();
      end
      reset = 1'b0;
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Target side of the CPU core's data memory interface. Decodes each address to either internal RAM or a memory-mapped I/O (MMIO) window.
- MMIO window contains a console TX FIFO drained over a valid/ready byte stream, plus a 16-bit free-running cycle counter.
- Reads are combinational, so data is returned in the same cycle. Writes commit on the rising clock edge.

Parameters:
- DATA_W, 8, data word width.
- D_ADDR_W, 12, data address width.
- MMIO_BASE, 12'hF00, first MMIO address. RAM occupies addresses 0 .. MMIO_BASE-1.
- FIFO_DEPTH, 4, console TX FIFO entries; must be a power of 2, 2..16.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- data_addr  in  D_ADDR_W  access address.
- write_data  in  DATA_W  write data.
- data_memory_write_enable  in  1  write strobe, sampled at clk edge.
- data_memory_output_enable  in  1  read enable.
- read_data  out  DATA_W  read data, combinational.
- tx_data  out  DATA_W  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts head.

Behaviour:
- Clocking and reset: one clock, clk; synchronous active-high reset.
- Reset state: FIFO empty, tx_valid=0, tx_data=0, overflow=0, cycle counter=0, hi_shadow=0. RAM contents are not reset.
- read_data:
  - Combinational; 0 when output_enable=0.
  - When output_enable=1 and we=1 in the same cycle, read_data returns pre-write contents and the write commits at the edge.
- RAM (addr < MMIO_BASE): asynchronous read; synchronous write when we=1.
- MMIO offsets (addr - MMIO_BASE):
  - 0x00 CON_DATA:
    - Write: push write_data into FIFO. If FIFO is full and no pop occurs that cycle, the byte is dropped and sticky overflow is set.
    - Read: 0.
  - 0x01 CON_STATUS:
    - Read: {4'b0, buserr, overflow, empty, full}.
    - Write (any value): clears overflow, and buserr when the optional feature is enabled.
  - 0x02 CYC_LO:
    - Read: returns counter[7:0]; at the same edge, latches counter[15:8] into hi_shadow.
    - Write (any value): counter becomes 0 at that edge, then increments from the next cycle.
  - 0x03 CYC_HI:
    - Read: returns hi_shadow.
    - Write: ignored.
  - Other MMIO offsets: read 0, write ignored.
- FIFO:
  - tx_data = head entry (0 when empty); tx_valid = !empty.
  - Pop on tx_valid && tx_ready at the edge.
  - Push and pop in the same cycle while full: both accepted, count unchanged, no overflow.
  - Push while empty: tx_valid rises the next cycle (1-cycle latency).
  - Pointers wrap modulo FIFO_DEPTH; full and empty are derived from a count of width clog2(FIFO_DEPTH)+1.
  - tx_valid never deasserts without a pop, except on reset.
- Cycle counter:
  - Increments every cycle; 0xFFFF wraps to 0x0000.
  - A clear via CYC_LO write has priority over the increment.
- Reset mid-operation: FIFO contents are discarded and tx_valid drops the next cycle regardless of tx_ready.

Optional Feature:
- Macro: DMEM_RESP_BUS_ERR_EN.
- When defined:
  - Adds output port bus_error (1 bit).
  - A read or write to an unmapped MMIO offset (0x04+) produces a registered 1-cycle pulse on bus_error the cycle after the access.
  - The same access sets sticky CON_STATUS bit3 (buserr), which is cleared by a CON_STATUS write or by reset.
- When undefined: the bus_error port is absent, bit3 reads 0, and unmapped accesses are silently ignored.

Test Plan:
- RAM access: write 0xA5 to addr 0x010, then read 0x010 with oe=1 -> read_data=0xA5 in the same cycle. Read 0x011 with oe=0 -> read_data=0.
- FIFO fill and overflow: tx_ready=0, write 0x41,0x42,0x43,0x44,0x45 to 0xF00 -> after the 4th push STATUS=0x01 (full). 5th byte dropped; STATUS=0x05. Then tx_ready=1 -> tx_data sequence 0x41..0x44, then STATUS=0x06. Write to 0xF01 -> STATUS=0x02.
- Simultaneous push/pop: FIFO full, tx_ready=1, write 0x55 to 0xF00 in the same cycle -> head pops, 0x55 is enqueued, overflow stays 0, count stays 4.
- Cycle counter: write 0xF02 at cycle N -> read 0xF02 at N+3 returns 0x02. Let the counter run to 0x01FE, read LO -> 0xFE; one cycle later read HI -> 0x01, even after LO has wrapped. Counter at 0xFFFF -> 0x0000 the next cycle.
- Reset: FIFO holding 3 bytes, assert reset for 1 cycle mid-drain -> tx_valid=0, STATUS=0x02, cycle counter 0, RAM data at 0x010 still 0xA5.
- Bus error (with DMEM_RESP_BUS_ERR_EN): read 0xF07 -> bus_error=1 for exactly the next cycle, STATUS bit3=1. Write to 0xF01 clears it. Without the macro: same access leaves STATUS=0x02.
